// File: rtl/network_train_sequencer.sv
// Sequences MLP inference passes and multi-epoch training runs over a sample stream.
// Optional macro LR_DECAY_EN: halve the learning rate (saturating at 1) on every epoch advance.
module network_train_sequencer #(
  parameter int             NI      = 4,
  parameter int             NO      = 7,
  parameter int             WV      = 8,
  parameter int             WO      = 12,
  parameter int             NS      = 16,
  parameter int             NE      = 4,
  parameter logic [WV-1:0]  LR_INIT = 8'h40
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iStart,
  input  logic                   iTrain,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oMode,
  output logic [WV-1:0]          oLR,
  output logic [$clog2(NE):0]    oEpoch,
  output logic [$clog2(NS):0]    oSample,
  input  logic                   iValid_AM_Sample,
  output logic                   oReady_AM_Sample,
  input  logic [NI*WV+NO*WO-1:0] iData_AM_Sample,
  output logic                   oValid_BM_Input,
  input  logic                   iReady_BM_Input,
  output logic [NI*WV-1:0]       oData_BM_Input,
  output logic                   oValid_BM_Teacher,
  input  logic                   iReady_BM_Teacher,
  output logic [NO*WO-1:0]       oData_BM_Teacher,
  input  logic                   iValid_AM_Output,
  output logic                   oReady_AM_Output,
  input  logic [NO*WO-1:0]       iData_AM_Output,
  output logic                   oValid_BM_Result,
  input  logic                   iReady_BM_Result,
  output logic [NO*WO-1:0]       oData_BM_Result
);
  localparam int EW = $clog2(NE) + 1;
  localparam int SW = $clog2(NS) + 1;
  localparam int IW = NI * WV;
  localparam int OW = NO * WO;
  localparam logic [EW-1:0] E_LAST = EW'(NE - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NS - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_COLLECT, S_DONE} state_t;
  state_t state, state_nx;

  logic smp_xfer, in_xfer, tch_xfer, out_xfer, res_xfer;
  logic in_left, tch_left, leave, last_sample, last_epoch, finish;

  assign oBusy            = (state != S_IDLE);
  assign oDone            = (state == S_DONE);
  assign oReady_AM_Sample = (state == S_FETCH);
  // Inference holds off the network until the previous result has drained.
  assign oReady_AM_Output = (state == S_COLLECT) && (oMode || !oValid_BM_Result);

  always_comb begin
    smp_xfer    = iValid_AM_Sample & oReady_AM_Sample;
    in_xfer     = oValid_BM_Input & iReady_BM_Input;
    tch_xfer    = oValid_BM_Teacher & iReady_BM_Teacher;
    out_xfer    = iValid_AM_Output & oReady_AM_Output;
    res_xfer    = oValid_BM_Result & iReady_BM_Result;
    in_left     = oValid_BM_Input & ~iReady_BM_Input;
    tch_left    = oValid_BM_Teacher & ~iReady_BM_Teacher;
    leave       = (state == S_COLLECT) && (oMode ? out_xfer : res_xfer);
    last_sample = (oSample == S_LAST);
    last_epoch  = (oEpoch == E_LAST);
    finish      = last_sample && (!oMode || last_epoch);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (iStart) state_nx = S_FETCH;
      S_FETCH:   if (smp_xfer) state_nx = S_ISSUE;
      S_ISSUE:   if (!in_left && !tch_left) state_nx = S_COLLECT;
      S_COLLECT: if (leave) state_nx = finish ? S_DONE : S_FETCH;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oMode             <= 1'b0;
      oLR               <= LR_INIT;
      oEpoch            <= '0;
      oSample           <= '0;
      oValid_BM_Input   <= 1'b0;
      oData_BM_Input    <= '0;
      oValid_BM_Teacher <= 1'b0;
      oData_BM_Teacher  <= '0;
      oValid_BM_Result  <= 1'b0;
      oData_BM_Result   <= '0;
    end else begin
      if (state == S_IDLE && iStart) begin
        oMode   <= iTrain;
        oLR     <= LR_INIT;
        oEpoch  <= '0;
        oSample <= '0;
      end
      if (smp_xfer) begin
        oData_BM_Input    <= iData_AM_Sample[IW-1:0];
        oData_BM_Teacher  <= iData_AM_Sample[IW +: OW];
        oValid_BM_Input   <= 1'b1;
        oValid_BM_Teacher <= oMode;
      end
      if (in_xfer)  oValid_BM_Input   <= 1'b0;
      if (tch_xfer) oValid_BM_Teacher <= 1'b0;
      if (out_xfer && !oMode) begin
        oValid_BM_Result <= 1'b1;
        oData_BM_Result  <= iData_AM_Output;
      end else if (res_xfer) begin
        oValid_BM_Result <= 1'b0;
        oData_BM_Result  <= '0;
      end
      if (leave) begin
        if (!last_sample) begin
          oSample <= oSample + SW'(1);
        end else begin
          oSample <= '0;
          if (oMode && !last_epoch) begin
            oEpoch <= oEpoch + EW'(1);
`ifdef LR_DECAY_EN
            oLR <= (oLR > WV'(1)) ? (oLR >> 1) : WV'(1);
`else
            oLR <= LR_INIT;
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_network_train_sequencer.sv
// Scoreboard bench for network_train_sequencer: models sample source, network and result sink.
// Honours LR_DECAY_EN for the expected learning rate.
module tb_network_train_sequencer;
  localparam int NI = 4, NO = 7, WV = 8, WO = 12, NS = 4, NE = 3;
  localparam logic [WV-1:0] LR_INIT = 8'h40;
  localparam int IW = NI * WV;
  localparam int OW = NO * WO;

  logic iCLK = 1'b0, iRST, iStart, iTrain;
  logic oBusy, oDone, oMode;
  logic [WV-1:0] oLR;
  logic [$clog2(NE):0] oEpoch;
  logic [$clog2(NS):0] oSample;
  logic iValid_AM_Sample, oReady_AM_Sample;
  logic [IW+OW-1:0] iData_AM_Sample;
  logic oValid_BM_Input, iReady_BM_Input;
  logic [IW-1:0] oData_BM_Input;
  logic oValid_BM_Teacher, iReady_BM_Teacher;
  logic [OW-1:0] oData_BM_Teacher;
  logic iValid_AM_Output, oReady_AM_Output;
  logic [OW-1:0] iData_AM_Output;
  logic oValid_BM_Result, iReady_BM_Result;
  logic [OW-1:0] oData_BM_Result;

  always #5 iCLK = ~iCLK;

  network_train_sequencer #(.NI(NI), .NO(NO), .WV(WV), .WO(WO), .NS(NS), .NE(NE), .LR_INIT(LR_INIT)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iTrain(iTrain),
    .oBusy(oBusy), .oDone(oDone), .oMode(oMode), .oLR(oLR), .oEpoch(oEpoch), .oSample(oSample),
    .iValid_AM_Sample(iValid_AM_Sample), .oReady_AM_Sample(oReady_AM_Sample), .iData_AM_Sample(iData_AM_Sample),
    .oValid_BM_Input(oValid_BM_Input), .iReady_BM_Input(iReady_BM_Input), .oData_BM_Input(oData_BM_Input),
    .oValid_BM_Teacher(oValid_BM_Teacher), .iReady_BM_Teacher(iReady_BM_Teacher), .oData_BM_Teacher(oData_BM_Teacher),
    .iValid_AM_Output(iValid_AM_Output), .oReady_AM_Output(oReady_AM_Output), .iData_AM_Output(iData_AM_Output),
    .oValid_BM_Result(oValid_BM_Result), .iReady_BM_Result(iReady_BM_Result), .oData_BM_Result(oData_BM_Result)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] net_fn(input logic [IW-1:0] x);
    return {x[19:0] ^ 20'h5a5a5, x ^ 32'hdeadbeef, x};
  endfunction

  function automatic logic [WV-1:0] lr_model(input int epoch);
    logic [WV-1:0] v;
`ifdef LR_DECAY_EN
    v = LR_INIT >> epoch;
    if (v == '0) v = WV'(1);
`else
    v = LR_INIT;
`endif
    return v;
  endfunction

  logic [IW-1:0] q_in[$];
  logic [OW-1:0] q_tch[$];
  logic [OW-1:0] q_res[$];

  bit model_en, train_exp;
  bit xs, xi, xt, xo, xr, in_done, tch_done, done_prev, tch_hold, res_hold;
  int fetches, outs, results, dones, exp_n;
  int tch_stall_cfg, res_stall_cfg, tch_stall_ctr, res_stall_ctr, out_cnt;
  logic [IW-1:0] src_in, net_in;
  logic [OW-1:0] src_tch, tch_prev, res_prev;

  task automatic model_clear();
    {xs, xi, xt, xo, xr, in_done, tch_done, done_prev, tch_hold, res_hold} = '0;
    out_cnt = 0; tch_stall_ctr = 0; res_stall_ctr = 0;
    iValid_AM_Output = 1'b0;
    q_in.delete(); q_tch.delete(); q_res.delete();
  endtask

  // Stimulus and checks on the falling edge; transfers complete on the following rising edge.
  always @(negedge iCLK) begin
    if (model_en) begin
      if (xs) begin
        fetches++;
        src_in  = IW'($urandom);
        src_tch = OW'({$urandom, $urandom, $urandom});
        iData_AM_Sample = {src_tch, src_in};
        tch_stall_ctr = tch_stall_cfg;
      end
      if (xi) in_done = 1'b1;
      if (xt) tch_done = 1'b1;
      if (xo) begin
        iValid_AM_Output = 1'b0;
        outs++;
        res_stall_ctr = res_stall_cfg;
      end
      if (xr) results++;
      if (in_done && (tch_done || !train_exp)) begin
        in_done = 1'b0; tch_done = 1'b0; out_cnt = 2;
      end

      iValid_AM_Sample = 1'b1;
      iReady_BM_Input  = 1'b1;
      if (tch_stall_ctr > 0) begin iReady_BM_Teacher = 1'b0; tch_stall_ctr--; end
      else iReady_BM_Teacher = 1'b1;
      if (res_stall_ctr > 0) begin iReady_BM_Result = 1'b0; res_stall_ctr--; end
      else iReady_BM_Result = 1'b1;
      if (out_cnt > 0) begin
        out_cnt--;
        if (out_cnt == 0) begin
          iValid_AM_Output = 1'b1;
          iData_AM_Output  = net_fn(net_in);
        end
      end

      xs = iValid_AM_Sample && oReady_AM_Sample;
      xi = oValid_BM_Input && iReady_BM_Input;
      xt = oValid_BM_Teacher && iReady_BM_Teacher;
      xo = iValid_AM_Output && oReady_AM_Output;
      xr = oValid_BM_Result && iReady_BM_Result;

      if (xs) begin
        check("in_flight", fetches - (train_exp ? outs : results), 0);
        check("fetch_epoch", oEpoch, fetches / NS);
        check("fetch_sample", oSample, fetches % NS);
        check("fetch_lr", oLR, lr_model(fetches / NS));
        check("fetch_mode", oMode, train_exp);
        q_in.push_back(src_in);
        if (train_exp) q_tch.push_back(src_tch);
        else q_res.push_back(net_fn(src_in));
      end
      if (xi) begin
        net_in = oData_BM_Input;
        if (q_in.size() == 0) check("input_unexpected", 1, 0);
        else check("input_data", oData_BM_Input, q_in.pop_front());
      end
      if (oValid_BM_Input && !train_exp) check("tch_vld_infer", oValid_BM_Teacher, 0);
      if (oValid_BM_Teacher && !iReady_BM_Teacher) begin
        if (tch_hold) check("tch_stable", oData_BM_Teacher, tch_prev);
        check("tch_stall_no_fetch", oReady_AM_Sample, 0);
        tch_prev = oData_BM_Teacher; tch_hold = 1'b1;
      end else tch_hold = 1'b0;
      if (xt) begin
        if (q_tch.size() == 0) check("teacher_unexpected", 1, 0);
        else check("teacher_data", oData_BM_Teacher, q_tch.pop_front());
      end
      if (train_exp && oReady_AM_Output) check("res_vld_train", oValid_BM_Result, 0);
      if (oValid_BM_Result && !iReady_BM_Result) begin
        if (res_hold) check("res_stable", oData_BM_Result, res_prev);
        check("res_stall_out_rdy", oReady_AM_Output, 0);
        check("res_stall_no_fetch", oReady_AM_Sample, 0);
        res_prev = oData_BM_Result; res_hold = 1'b1;
      end else res_hold = 1'b0;
      if (xr) begin
        if (q_res.size() == 0) check("result_unexpected", 1, 0);
        else check("result_data", oData_BM_Result, q_res.pop_front());
      end
      if (done_prev) check("busy_after_done", oBusy, 0);
      if (oDone) begin
        dones++;
        check("done_fetches", fetches, exp_n);
        check("done_outputs", outs, exp_n);
        check("done_results", results, train_exp ? 0 : exp_n);
      end
      done_prev = oDone;
    end
  end

  task automatic start_run(input bit train, input int tcfg, input int rcfg);
    fetches = 0; outs = 0; results = 0;
    train_exp = train; tch_stall_cfg = tcfg; res_stall_cfg = rcfg;
    exp_n = train ? NS * NE : NS;
    iTrain = train; iStart = 1'b1;
    @(posedge iCLK); #1;
    iStart = 1'b0;
  endtask

  task automatic run_pass(input bit train, input int tcfg, input int rcfg);
    int d0;
    d0 = dones;
    start_run(train, tcfg, rcfg);
    for (int c = 0; c < 3000 && dones == d0; c++) begin
      @(posedge iCLK); #1;
    end
    check("run_done_count", dones - d0, 1);
    check("run_queues_empty", q_in.size() + q_tch.size() + q_res.size(), 0);
  endtask

  initial begin
    bit found;
    iRST = 1'b0; iStart = 1'b0; iTrain = 1'b0; model_en = 1'b0; dones = 0;
    iValid_AM_Sample = 1'b0; iReady_BM_Input = 1'b0; iReady_BM_Teacher = 1'b0;
    iReady_BM_Result = 1'b0; iData_AM_Output = '0; net_in = '0;
    src_in = IW'($urandom);
    src_tch = OW'({$urandom, $urandom, $urandom});
    iData_AM_Sample = {src_tch, src_in};
    model_clear();
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_mode", oMode, 0);
    check("rst_lr", oLR, LR_INIT);
    check("rst_epoch", oEpoch, 0);
    check("rst_sample", oSample, 0);
    check("rst_rdy_sample", oReady_AM_Sample, 0);
    check("rst_vld_input", oValid_BM_Input, 0);
    check("rst_vld_teacher", oValid_BM_Teacher, 0);
    check("rst_vld_result", oValid_BM_Result, 0);
    check("rst_rdy_output", oReady_AM_Output, 0);
    check("rst_data_input", oData_BM_Input, 0);
    iRST = 1'b1; model_en = 1'b1;

    run_pass(1'b0, 0, 0);
    run_pass(1'b1, 0, 0);
    run_pass(1'b1, 6, 0);
    run_pass(1'b0, 0, 8);

    start_run(1'b1, 0, 0);
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(posedge iCLK); #1;
      found = (oEpoch == 1 && oSample == 2 && oValid_BM_Input);
    end
    check("midrun_reached", found, 1);
    iRST = 1'b0; model_en = 1'b0;
    #1;
    check("midrun_vld_input", oValid_BM_Input, 0);
    check("midrun_vld_teacher", oValid_BM_Teacher, 0);
    check("midrun_rdy_sample", oReady_AM_Sample, 0);
    check("midrun_busy", oBusy, 0);
    check("midrun_epoch", oEpoch, 0);
    check("midrun_sample", oSample, 0);
    check("midrun_lr", oLR, LR_INIT);
    model_clear();
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b1; model_en = 1'b1;
    run_pass(1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
